// File: rtl/s713_bist_pkg.sv
// Shared definitions for the s713 BIST sequencer.
//   - Default CUT interface widths and the pattern-counter width.
//   - Feedback tap positions for the stimulus LFSR and the response MISR.
//   - The seed that replaces an all-zero seed, which would lock the LFSR up.
//   - The sequencer state encoding.
package s713_bist_pkg;

  localparam int NPI_DEF      = 35;  // CUT primary inputs (LFSR width)
  localparam int NPO_DEF      = 23;  // CUT primary outputs (MISR width)
  localparam int CNT_W_DEF    = 16;  // pattern counter width
  localparam int LFSR_TAP_DEF = 32;  // x^35 + x^33 + 1
  localparam int MISR_TAP_DEF = 17;  // x^23 + x^18 + 1

  // An all-zero LFSR never leaves zero, so a zero seed is replaced with this value.
  localparam int unsigned ZERO_SEED_SUB = 1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_INIT  = 2'd1,
    ST_APPLY = 2'd2,
    ST_DONE  = 2'd3
  } bist_state_e;

endpackage

// File: rtl/s713_bist_misr.sv
// Multiple-input signature register used to compact CUT responses.
// Ports:
//   clk_i     clock, rising edge
//   rst_ni    asynchronous active-low reset; clears the signature
//   clr_i     synchronous clear; has priority over en_i
//   en_i      fold d_i into the signature this cycle
//   d_i       parallel response word
//   sig_o     registered signature
//   sig_nxt_o value the signature takes at the next edge
module bist_misr #(
  parameter int W   = 23,
  parameter int TAP = 17
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         clr_i,
  input  logic         en_i,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] sig_o,
  output logic [W-1:0] sig_nxt_o
);

  logic [W-1:0] sig_q;

  always_comb begin
    sig_nxt_o = sig_q;
    if (clr_i) begin
      sig_nxt_o = '0;
    end else if (en_i) begin
      sig_nxt_o = {sig_q[W-2:0], sig_q[W-1] ^ sig_q[TAP]} ^ d_i;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sig_q <= '0;
    end else begin
      sig_q <= sig_nxt_o;
    end
  end

  assign sig_o = sig_q;

endmodule

// File: rtl/s713_bist_ctrl.sv
// Built-in self-test sequencer for the s713 core.
// An LFSR drives pseudo-random stimulus onto the CUT inputs, a MISR compacts
// the CUT outputs over a programmed number of patterns, and the final
// signature is compared against a golden value.
// Ports:
//   clk_i       clock, rising edge
//   rst_ni      asynchronous active-low reset
//   start_i     level-sampled run request (honoured in IDLE and DONE)
//   abort_i     return to IDLE from any state; wins over start_i
//   num_pat_i   patterns per run, sampled with start_i
//   seed_i      LFSR seed, sampled with start_i
//   golden_i    expected signature, compared continuously
//   pi_o        stimulus to the CUT primary inputs
//   po_i        CUT primary outputs
//   cut_rstn_o  CUT flop reset, active-low
//   busy_o      high in INIT and APPLY
//   done_o      high in DONE
//   sig_o       current MISR contents
//   pass_o      DONE and signature matches golden_i
module s713_bist_ctrl
  import s713_bist_pkg::*;
#(
  parameter int NPI      = NPI_DEF,
  parameter int NPO      = NPO_DEF,
  parameter int CNT_W    = CNT_W_DEF,
  parameter int LFSR_TAP = LFSR_TAP_DEF,
  parameter int MISR_TAP = MISR_TAP_DEF
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             start_i,
  input  logic             abort_i,
  input  logic [CNT_W-1:0] num_pat_i,
  input  logic [NPI-1:0]   seed_i,
  input  logic [NPO-1:0]   golden_i,
  output logic [NPI-1:0]   pi_o,
  input  logic [NPO-1:0]   po_i,
  output logic             cut_rstn_o,
  output logic             busy_o,
  output logic             done_o,
  output logic [NPO-1:0]   sig_o,
  output logic             pass_o
);

  bist_state_e      state_q, state_d;
  logic [NPI-1:0]   lfsr_q, lfsr_d;
  logic [NPI-1:0]   pi_q, pi_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] npat_q, npat_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             crstn_q, crstn_d;
  logic             pass_q, pass_d;

  logic             misr_clr, misr_en;
  logic [NPO-1:0]   sig_nxt;
  logic             last_pat;

  // Only evaluated in APPLY, where the latched pattern count is non-zero.
  assign last_pat = (cnt_q == (npat_q - CNT_W'(1)));

  always_comb begin
    state_d  = state_q;
    lfsr_d   = lfsr_q;
    cnt_d    = cnt_q;
    npat_d   = npat_q;
    misr_clr = 1'b0;
    misr_en  = 1'b0;

    if (abort_i) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE, ST_DONE: begin
          if (start_i) begin
            state_d  = ST_INIT;
            npat_d   = num_pat_i;
            lfsr_d   = (seed_i == '0) ? NPI'(ZERO_SEED_SUB) : seed_i;
            cnt_d    = '0;
            misr_clr = 1'b1;
          end
        end
        ST_INIT: begin
          state_d = (npat_q != '0) ? ST_APPLY : ST_DONE;
        end
        ST_APPLY: begin
          // The PO seen this cycle belongs to the PI currently on pi_o.
          misr_en = 1'b1;
          lfsr_d  = {lfsr_q[NPI-2:0], lfsr_q[NPI-1] ^ lfsr_q[LFSR_TAP]};
          cnt_d   = cnt_q + CNT_W'(1);
          if (last_pat) begin
            state_d = ST_DONE;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end

    // Outputs are registered from next-state values so they line up with the state.
    // On INIT->APPLY lfsr_d still holds the seed, so the first pattern is the seed.
    pi_d    = (state_d == ST_APPLY) ? lfsr_d : '0;
    busy_d  = (state_d == ST_INIT) || (state_d == ST_APPLY);
    done_d  = (state_d == ST_DONE);
    crstn_d = (state_d == ST_APPLY) || (state_d == ST_DONE);
    pass_d  = done_d && (sig_nxt == golden_i);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= ST_IDLE;
      lfsr_q  <= '0;
      pi_q    <= '0;
      cnt_q   <= '0;
      npat_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      crstn_q <= 1'b0;
      pass_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      lfsr_q  <= lfsr_d;
      pi_q    <= pi_d;
      cnt_q   <= cnt_d;
      npat_q  <= npat_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      crstn_q <= crstn_d;
      pass_q  <= pass_d;
    end
  end

  bist_misr #(
    .W   (NPO),
    .TAP (MISR_TAP)
  ) u_misr (
    .clk_i     (clk_i),
    .rst_ni    (rst_ni),
    .clr_i     (misr_clr),
    .en_i      (misr_en),
    .d_i       (po_i),
    .sig_o     (sig_o),
    .sig_nxt_o (sig_nxt)
  );

  assign pi_o       = pi_q;
  assign cut_rstn_o = crstn_q;
  assign busy_o     = busy_q;
  assign done_o     = done_q;
  assign pass_o     = pass_q;

endmodule

// File: tb/tb_s713_bist_ctrl.sv
// Bench for s713_bist_ctrl: a behavioural CUT stub answers PI with PO, the
// expected PI stream and final signature are queued when a run is launched
// and popped as the sequencer produces them.
module tb_s713_bist_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic [15:0] num_pat = '0;
  logic [34:0] seed = '0;
  logic [22:0] golden = '0;
  logic [34:0] pi;
  logic [22:0] po;
  logic        cut_rstn, busy, done, pass;
  logic [22:0] sig;
  int          po_mode = 0;

  int n_chk = 0;
  int n_err = 0;

  logic [34:0] exp_pi[$];
  logic [22:0] exp_sig[$];

  s713_bist_ctrl dut (
    .clk_i      (clk),
    .rst_ni     (rst_n),
    .start_i    (start),
    .abort_i    (abort),
    .num_pat_i  (num_pat),
    .seed_i     (seed),
    .golden_i   (golden),
    .pi_o       (pi),
    .po_i       (po),
    .cut_rstn_o (cut_rstn),
    .busy_o     (busy),
    .done_o     (done),
    .sig_o      (sig),
    .pass_o     (pass)
  );

  always #5 clk = ~clk;

  function automatic logic [34:0] m_lfsr(input logic [34:0] x);
    return {x[33:0], x[34] ^ x[32]};
  endfunction

  function automatic logic [22:0] m_misr(input logic [22:0] m, input logic [22:0] p);
    return {m[21:0], m[22] ^ m[17]} ^ p;
  endfunction

  // CUT stub: mode 0 = outputs tied low, 1 = low PI bits, 2 = scrambled PI.
  function automatic logic [22:0] m_po(input int mode, input logic [34:0] x);
    case (mode)
      0:       return '0;
      1:       return x[22:0];
      default: return x[22:0] ^ x[34:12] ^ 23'h5A5A5A;
    endcase
  endfunction

  always_comb po = m_po(po_mode, pi);

  // Signature after the first k patterns of a run.
  function automatic logic [22:0] m_sig(input logic [34:0] s, input int k, input int mode);
    logic [34:0] x;
    logic [22:0] m;
    x = (s == '0) ? 35'd1 : s;
    m = '0;
    for (int i = 0; i < k; i++) begin
      m = m_misr(m, m_po(mode, x));
      x = m_lfsr(x);
    end
    return m;
  endfunction

  task automatic push_run(input logic [34:0] s, input int n, input int mode);
    logic [34:0] x;
    x = (s == '0) ? 35'd1 : s;
    for (int i = 0; i < n; i++) begin
      exp_pi.push_back(x);
      x = m_lfsr(x);
    end
    exp_sig.push_back(m_sig(s, n, mode));
  endtask

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h want 0x%0h", tag, act, exp);
    end
  endtask

  task automatic run(input logic [34:0] s, input int n, input int mode, input logic [22:0] gold);
    int napply;
    int iters;
    logic [22:0] e;
    @(negedge clk);
    po_mode = mode;
    seed    = s;
    num_pat = 16'(n);
    golden  = gold;
    start   = 1'b1;
    push_run(s, n, mode);
    @(negedge clk);
    start = 1'b0;
    chk("init_busy", busy, 1);
    chk("init_done", done, 0);
    chk("init_pi", pi, 0);
    chk("init_cutrst", cut_rstn, 0);
    napply = 0;
    iters  = 0;
    while (!done && iters < n + 5) begin
      @(negedge clk);
      iters++;
      if (busy && cut_rstn) begin
        napply++;
        if (exp_pi.size() > 0) chk("pi", pi, exp_pi.pop_front());
        else chk("pi_extra", pi, 0);
      end
    end
    if (!done) chk("timeout_done", done, 1);
    chk("latency", iters, n + 1);
    chk("napply", napply, n);
    chk("done_busy", busy, 0);
    chk("done_pi", pi, 0);
    chk("done_cutrst", cut_rstn, 1);
    e = (exp_sig.size() > 0) ? exp_sig.pop_front() : 23'h7FFFFF;
    chk("sig", sig, e);
    chk("pass", pass, (e == gold));
  endtask

  initial begin
    logic [22:0] m4;
    int          napply;
    int          iters;

    // Reset state
    #12;
    chk("rst_pi", pi, 0);
    chk("rst_cutrst", cut_rstn, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_sig", sig, 0);
    chk("rst_pass", pass, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("idle_busy", busy, 0);

    // Seed 1, three patterns, PO tied low: PI walks 1,2,4 and SIG stays zero
    run(35'd1, 3, 0, 23'd0);

    // Seed 1, two patterns, PO = 1 then 2 folds back to zero
    run(35'd1, 2, 1, 23'd0);
    @(negedge clk);
    golden = 23'd1;
    @(negedge clk);
    chk("pass_live_lo", pass, 0);
    chk("sig_frozen", sig, 0);
    golden = 23'd0;
    @(negedge clk);
    chk("pass_live_hi", pass, 1);

    // Zero seed is replaced by 1; single pattern
    run(35'd0, 1, 2, m_sig(35'd0, 1, 2));

    // Zero patterns: INIT straight to DONE, PI never driven
    run(35'h12345, 0, 2, 23'd0);

    // Longer scrambled run with a mismatching golden
    run(35'h4_DEAD_BEEF, 20, 2, 23'h000001);

    // ABORT from DONE drops DONE/PASS, keeps SIG, resets the CUT
    run(35'h3, 6, 2, m_sig(35'h3, 6, 2));
    @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("abdone_done", done, 0);
    chk("abdone_pass", pass, 0);
    chk("abdone_cutrst", cut_rstn, 0);
    chk("abdone_sig", sig, m_sig(35'h3, 6, 2));

    // ABORT wins over START in IDLE
    start = 1'b1;
    abort = 1'b1;
    @(negedge clk);
    start = 1'b0;
    abort = 1'b0;
    chk("abort_prio_busy", busy, 0);

    // ABORT on APPLY cycle 5 of 100
    po_mode = 2;
    seed    = 35'h1234_5678;
    num_pat = 16'd100;
    start   = 1'b1;
    push_run(35'h1234_5678, 100, 2);
    @(negedge clk);
    start  = 1'b0;
    napply = 0;
    iters  = 0;
    while (napply < 5 && iters < 20) begin
      @(negedge clk);
      iters++;
      if (busy && cut_rstn) begin
        napply++;
        chk("ab_pi", pi, exp_pi.pop_front());
      end
    end
    chk("ab_reached", napply, 5);
    m4 = m_sig(35'h1234_5678, 4, 2);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("ab_busy", busy, 0);
    chk("ab_done", done, 0);
    chk("ab_cutrst", cut_rstn, 0);
    chk("ab_pi0", pi, 0);
    chk("ab_sig_kept", sig, m4);
    exp_pi.delete();
    exp_sig.delete();
    @(negedge clk);
    chk("ab_stay_idle", busy, 0);
    run(35'h1234_5678, 100, 2, m_sig(35'h1234_5678, 100, 2));

    // Asynchronous reset between edges in the middle of APPLY
    @(negedge clk);
    po_mode = 2;
    seed    = 35'h5;
    num_pat = 16'd50;
    start   = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    chk("mid_busy", busy, 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_pi", pi, 0);
    chk("arst_busy", busy, 0);
    chk("arst_cutrst", cut_rstn, 0);
    chk("arst_done", done, 0);
    chk("arst_sig", sig, 0);
    chk("arst_pass", pass, 0);
    start = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("arst_start_ign", busy, 0);
    start = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);
    chk("arst_rel_busy", busy, 0);
    chk("arst_rel_done", done, 0);

    // Clean run after reset
    run(35'h7_0000_0001, 8, 2, m_sig(35'h7_0000_0001, 8, 2));

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
